// File: rtl/vga_rect_fill_engine.sv
// vga_rect_fill_engine
//   Drawing engine for the write port of the VGA video RAM wrapper. Accepts one
//   rectangle-fill or full-screen-clear command and emits one pixel write per
//   cycle in raster order (column fastest).
// Ports
//   Clock, Reset        : clock (posedge) and asynchronous active-low reset
//   iStart, iClear      : command strobe (IDLE only) and full-screen select
//   iX0/iX1, iY0/iY1    : rectangle corners, any order
//   iColor              : fill colour
//   iHold               : stall request, freezes the fill while high
//   oBusy, oDone        : command in progress / one-cycle completion pulse
//   oWriteEnable, oWriteCol, oWriteRow, oRGB : RAM write port (all registered)
module vga_rect_fill_engine #(
  parameter int unsigned COL_W   = 11,
  parameter int unsigned ROW_W   = 10,
  parameter int unsigned RGB_W   = 3,
  parameter int unsigned MAX_COL = 639,
  parameter int unsigned MAX_ROW = 479
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iClear,
  input  logic [COL_W-1:0] iX0,
  input  logic [COL_W-1:0] iX1,
  input  logic [ROW_W-1:0] iY0,
  input  logic [ROW_W-1:0] iY1,
  input  logic [RGB_W-1:0] iColor,
  input  logic             iHold,
  output logic             oBusy,
  output logic             oDone,
  output logic             oWriteEnable,
  output logic [COL_W-1:0] oWriteCol,
  output logic [ROW_W-1:0] oWriteRow,
  output logic [RGB_W-1:0] oRGB
);

  localparam logic [COL_W-1:0] MaxCol = COL_W'(MAX_COL);
  localparam logic [ROW_W-1:0] MaxRow = ROW_W'(MAX_ROW);

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic             clear_q, clear_d;
  logic [COL_W-1:0] x0_q, x0_d, x1_q, x1_d, col_q, col_d, wcol_q, wcol_d;
  logic [ROW_W-1:0] y0_q, y0_d, y1_q, y1_d, row_q, row_d, wrow_q, wrow_d;
  logic [RGB_W-1:0] color_q, color_d, rgb_q, rgb_d;
  logic             we_q, we_d, busy_q, busy_d, done_q, done_d;

  // Normalised bounds of the latched command, used only in SETUP.
  logic [COL_W-1:0] lo_x, hi_x;
  logic [ROW_W-1:0] lo_y, hi_y;
  logic             off_screen;

  always_comb begin
    lo_x = (x0_q <= x1_q) ? x0_q : x1_q;
    hi_x = (x0_q <= x1_q) ? x1_q : x0_q;
    lo_y = (y0_q <= y1_q) ? y0_q : y1_q;
    hi_y = (y0_q <= y1_q) ? y1_q : y0_q;
    if (hi_x > MaxCol) hi_x = MaxCol;
    if (hi_y > MaxRow) hi_y = MaxRow;
    if (clear_q) begin
      lo_x = '0;
      hi_x = MaxCol;
      lo_y = '0;
      hi_y = MaxRow;
    end
    off_screen = (lo_x > MaxCol) || (lo_y > MaxRow);
  end

  always_comb begin
    state_d = state_q;
    clear_d = clear_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    color_d = color_q;
    col_d   = col_q;
    row_d   = row_q;
    wcol_d  = wcol_q;
    wrow_d  = wrow_q;
    rgb_d   = rgb_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          clear_d = iClear;
          x0_d    = iX0;
          x1_d    = iX1;
          y0_d    = iY0;
          y1_d    = iY1;
          color_d = iColor;
          state_d = StSetup;
        end
      end
      StSetup: begin
        // Bounds are rewritten in place so FILL sees x0<=x1, y0<=y1, clamped.
        x0_d = lo_x;
        x1_d = hi_x;
        y0_d = lo_y;
        y1_d = hi_y;
        if (off_screen) begin
          state_d = StDone;
        end else begin
          col_d   = lo_x;
          row_d   = lo_y;
          state_d = StFill;
        end
      end
      StFill: begin
        // On hold the write-port registers keep their previous values.
        if (!iHold) begin
          we_d   = 1'b1;
          wcol_d = col_q;
          wrow_d = row_q;
          rgb_d  = color_q;
          if (col_q < x1_q) begin
            col_d = col_q + 1'b1;
          end else if (row_q < y1_q) begin
            col_d = x0_q;
            row_d = row_q + 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Busy covers the last write too, since outputs lag the state by one edge.
    busy_d = (state_d == StSetup) || (state_d == StFill) || we_d;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      clear_q <= 1'b0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wcol_q  <= '0;
      wrow_q  <= '0;
      rgb_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wcol_q  <= wcol_d;
      wrow_q  <= wrow_d;
      rgb_q   <= rgb_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oBusy        = busy_q;
  assign oDone        = done_q;
  assign oWriteEnable = we_q;
  assign oWriteCol    = wcol_q;
  assign oWriteRow    = wrow_q;
  assign oRGB         = rgb_q;

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Self-checking bench for vga_rect_fill_engine. The screen is shrunk to 64x48
// so a full clear stays short; coordinate widths keep their real values.
module tb_vga_rect_fill_engine;

  localparam int unsigned CW = 11;
  localparam int unsigned RW = 10;
  localparam int unsigned GW = 3;
  localparam int MC = 63;
  localparam int MR = 47;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iStart = 1'b0, iClear = 1'b0, iHold = 1'b0;
  logic [CW-1:0] iX0 = '0, iX1 = '0;
  logic [RW-1:0] iY0 = '0, iY1 = '0;
  logic [GW-1:0] iColor = '0;
  logic          oBusy, oDone, oWriteEnable;
  logic [CW-1:0] oWriteCol;
  logic [RW-1:0] oWriteRow;
  logic [GW-1:0] oRGB;

  int n_assert = 0;
  int n_fail   = 0;

  vga_rect_fill_engine #(
    .COL_W(CW), .ROW_W(RW), .RGB_W(GW), .MAX_COL(MC), .MAX_ROW(MR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iClear(iClear),
    .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1), .iColor(iColor), .iHold(iHold),
    .oBusy(oBusy), .oDone(oDone), .oWriteEnable(oWriteEnable),
    .oWriteCol(oWriteCol), .oWriteRow(oWriteRow), .oRGB(oRGB)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input longint got, input longint want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic int pk(input int c, input int r);
    return (c << 16) | r;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Modes: 0 plain, 1 random hold, 2 3-cycle hold after 2nd write, 3 iStart mid-fill.
  task automatic run_cmd(input bit clr, input int x0, input int x1, input int y0, input int y1,
                         input logic [GW-1:0] col, input int mode);
    int exp_q[$];
    int obs_q[$];
    int lx, hx, ly, hy;
    int first_k = -1, last_k = -1, done_k = -1, done_cnt = 0;
    int busy_bad = 0, rgb_bad = 0, hold_bad = 0, hold_left = 0, bad_idx = -1;
    int held_c = 0, held_r = 0, held_g = 0;
    int budget;
    bit finished = 0;

    // Reference: the set of pixels the command covers, in raster order.
    if (clr) begin
      lx = 0; hx = MC; ly = 0; hy = MR;
    end else begin
      lx = mn(x0, x1); hx = mn(x0 + x1 - lx, MC);
      ly = mn(y0, y1); hy = mn(y0 + y1 - ly, MR);
    end
    if (lx <= MC && ly <= MR)
      for (int r = ly; r <= hy; r++)
        for (int c = lx; c <= hx; c++) exp_q.push_back(pk(c, r));
    budget = exp_q.size() * 4 + 40;

    @(negedge Clock);
    iStart = 1'b1; iClear = clr; iColor = col; iHold = 1'b0;
    iX0 = CW'(x0); iX1 = CW'(x1); iY0 = RW'(y0); iY1 = RW'(y1);
    for (int k = 1; k <= budget && !finished; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        // Inputs after acceptance must not matter.
        iStart = 1'b0; iClear = $urandom_range(0, 1); iColor = ~col;
        iX0 = CW'($urandom); iX1 = CW'($urandom); iY0 = RW'($urandom); iY1 = RW'($urandom);
      end
      if (oWriteEnable) begin
        obs_q.push_back(pk(oWriteCol, oWriteRow));
        if (first_k < 0) first_k = k;
        last_k = k;
        if (oRGB !== col) rgb_bad++;
      end
      if (oDone) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        if (oBusy || oWriteEnable) busy_bad++;
      end else if (done_k < 0 && exp_q.size() > 0 && !oBusy) begin
        busy_bad++;
      end
      if (hold_left > 0) begin
        if (oWriteEnable !== 1'b0 || oWriteCol !== CW'(held_c) || oWriteRow !== RW'(held_r) ||
            oRGB !== GW'(held_g)) hold_bad++;
        hold_left--;
        if (hold_left == 0) iHold = 1'b0;
      end else if (mode == 1) begin
        iHold = ($urandom_range(0, 3) == 0);
      end else if (mode == 2 && oWriteEnable && obs_q.size() == 2) begin
        iHold = 1'b1; hold_left = 3;
        held_c = oWriteCol; held_r = oWriteRow; held_g = oRGB;
      end
      if (mode == 3) iStart = (oWriteEnable && obs_q.size() == 3);
      if (done_k > 0 && k >= done_k + 2) finished = 1;
    end
    iHold = 1'b0; iStart = 1'b0;

    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (bad_idx < 0 && obs_q[i] != exp_q[i]) bad_idx = i;
    chk("done_seen", done_k > 0, 1);
    chk("done_once", done_cnt, 1);
    chk("write_count", obs_q.size(), exp_q.size());
    chk("pixel_order_first_bad_index", bad_idx, -1);
    chk("rgb_errors", rgb_bad, 0);
    chk("busy_errors", busy_bad, 0);
    if (mode == 2) chk("hold_errors", hold_bad, 0);
    if (exp_q.size() > 0) begin
      chk("done_after_last_write", done_k, last_k + 1);
      if (mode != 1) chk("first_write_latency", first_k, 3);
    end else begin
      chk("offscreen_done_latency", done_k, 3);
    end
  endtask

  initial begin
    int wr;
    repeat (3) @(negedge Clock);
    chk("reset_outputs", {oBusy, oDone, oWriteEnable, oWriteCol, oWriteRow, oRGB}, 0);
    Reset = 1'b1;

    run_cmd(0, 10, 12, 5, 6, 3'b101, 0);
    run_cmd(0, 12, 10, 6, 5, 3'b101, 0);
    run_cmd(1, 7, 3, 9, 2, 3'b000, 0);
    run_cmd(0, 60, 100, 47, 47, 3'b111, 0);
    run_cmd(0, 80, 80, 3, 3, 3'b010, 0);
    run_cmd(0, 20, 21, 8, 9, 3'b110, 2);
    run_cmd(0, 5, 14, 2, 4, 3'b001, 3);

    // Reset mid-fill: outputs clear asynchronously and stay clear.
    @(negedge Clock);
    iStart = 1'b1; iClear = 1'b0; iX0 = 0; iX1 = 30; iY0 = 0; iY1 = 5; iColor = 3'b011;
    @(negedge Clock);
    iStart = 1'b0;
    wr = 0;
    for (int k = 0; k < 40 && wr < 5; k++) begin
      @(negedge Clock);
      if (oWriteEnable) wr++;
    end
    chk("writes_before_reset", wr, 5);
    #2 Reset = 1'b0;
    #1 chk("async_reset_outputs", {oBusy, oDone, oWriteEnable, oWriteCol, oWriteRow, oRGB}, 0);
    @(negedge Clock);
    chk("held_reset_outputs", {oBusy, oDone, oWriteEnable, oWriteCol, oWriteRow, oRGB}, 0);
    Reset = 1'b1;
    @(negedge Clock);
    chk("idle_after_reset", {oBusy, oWriteEnable}, 0);
    run_cmd(0, 1, 3, 1, 1, 3'b100, 0);

    for (int t = 0; t < 8; t++)
      run_cmd($urandom_range(0, 7) == 0, $urandom_range(0, MC + 16), $urandom_range(0, MC + 16),
              $urandom_range(0, MR + 12), $urandom_range(0, MR + 12),
              GW'($urandom), $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
